// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue
//
// Instruction queue sitting between the icache interface and decode. Each
// accepted fetch packet {pc, inst, ex_valid, ex_cause} is written into a
// small circular FIFO so icache latency and decode stalls are decoupled.
// Once a packet carrying a fetch exception is accepted, intake is locked
// until a flush, so nothing younger than a faulting fetch is ever queued.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   flush_i             drop all entries and clear the exception lock
//   in_*                fetch packet input channel (valid/ready)
//   out_*               head-of-queue output channel to decode (valid/ready)
//   count_o             current occupancy, 0..DEPTH
//   ex_pending_o        exception lock active (registered)
//
// Handshake: a transfer happens on a channel in a cycle where valid and
// ready are both high at the rising clock edge. in_ready_o and out_valid_o
// depend only on registered state and flush_i, never on the opposite
// channel, so a pop does not free a slot for a push in the same cycle and
// there is no combinational path from in_valid_i/out_ready_i to the outputs.
// out_* data are meaningful only while out_valid_o is high.

module fetch_inst_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 40,
  parameter int CAUSE_W = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [ADDR_W-1:0]          in_pc_i,
  input  logic [31:0]                in_inst_i,
  input  logic                       in_ex_valid_i,
  input  logic [CAUSE_W-1:0]         in_ex_cause_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ADDR_W-1:0]          out_pc_o,
  output logic [31:0]                out_inst_o,
  output logic                       out_ex_valid_o,
  output logic [CAUSE_W-1:0]         out_ex_cause_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       ex_pending_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [31:0]        inst;
    logic               ex_valid;
    logic [CAUSE_W-1:0] ex_cause;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ex_lock_q, ex_lock_d;

  logic               push;
  logic               pop;
  entry_t             head;

  // Flush gates both channels so a flush cycle never moves data.
  assign in_ready_o  = (count_q < DEPTH_C) & ~ex_lock_q & ~flush_i;
  assign out_valid_o = (count_q != '0) & ~flush_i;

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  assign head           = mem_q[rd_ptr_q];
  assign out_pc_o       = head.pc;
  assign out_inst_o     = head.inst;
  assign out_ex_valid_o = head.ex_valid;
  assign out_ex_cause_o = head.ex_cause;
  assign count_o        = count_q;
  assign ex_pending_o   = ex_lock_q;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ex_lock_d = ex_lock_q;

    if (flush_i) begin
      // Entry contents are left in place; only bookkeeping is cleared.
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      ex_lock_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: in_pc_i, inst: in_inst_i,
                            ex_valid: in_ex_valid_i, ex_cause: in_ex_cause_i};
        // DEPTH is a power of two, so pointer wrap is the natural overflow.
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (in_ex_valid_i) begin
          ex_lock_d = 1'b1;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Storage is cleared too so the out_* data read as zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ex_lock_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ex_lock_q <= ex_lock_d;
    end
  end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Testbench for fetch_inst_queue: a table of directed vectors with
// hand-derived expectations, a steady-stream sequence, and randomized
// traffic compared against a queue-based reference model.

module tb_fetch_inst_queue;

  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 40;
  localparam int CAUSE_W = 64;
  localparam int CNT_W   = $clog2(DEPTH+1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_i, flush_i, in_valid_i, in_ready_o;
  logic [ADDR_W-1:0]  in_pc_i;
  logic [31:0]        in_inst_i;
  logic               in_ex_valid_i;
  logic [CAUSE_W-1:0] in_ex_cause_i;
  logic               out_valid_o, out_ready_i;
  logic [ADDR_W-1:0]  out_pc_o;
  logic [31:0]        out_inst_o;
  logic               out_ex_valid_o;
  logic [CAUSE_W-1:0] out_ex_cause_o;
  logic [CNT_W-1:0]   count_o;
  logic               ex_pending_o;

  fetch_inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CAUSE_W(CAUSE_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_pc_i(in_pc_i), .in_inst_i(in_inst_i),
    .in_ex_valid_i(in_ex_valid_i), .in_ex_cause_i(in_ex_cause_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
    .out_ex_valid_o(out_ex_valid_o), .out_ex_cause_o(out_ex_cause_o),
    .count_o(count_o), .ex_pending_o(ex_pending_o)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [ADDR_W-1:0]  pc;
    logic [31:0]        inst;
    logic               ex;
    logic [CAUSE_W-1:0] cause;
  } pkt_t;

  pkt_t mq[$];
  logic m_lock = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] inst_of(input logic [ADDR_W-1:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic flush, input logic valid,
                       input logic [ADDR_W-1:0] pc, input logic [31:0] inst,
                       input logic ex, input logic [CAUSE_W-1:0] cause,
                       input logic ordy);
    rst_i         = rst;
    flush_i       = flush;
    in_valid_i    = valid;
    in_pc_i       = pc;
    in_inst_i     = inst;
    in_ex_valid_i = ex;
    in_ex_cause_i = cause;
    out_ready_i   = ordy;
    #1;
  endtask

  // Advance one clock and apply the queue rules to the model.
  task automatic step();
    logic m_push, m_pop;
    pkt_t p;
    m_push = in_valid_i && (mq.size() < DEPTH) && !m_lock && !flush_i;
    m_pop  = (mq.size() != 0) && !flush_i && out_ready_i;
    p = '{pc: in_pc_i, inst: in_inst_i, ex: in_ex_valid_i, cause: in_ex_cause_i};
    @(posedge clk);
    if (rst_i || flush_i) begin
      mq.delete();
      m_lock = 1'b0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back(p);
        if (p.ex) m_lock = 1'b1;
      end
    end
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_in_ready"},  in_ready_o,
        (mq.size() < DEPTH) && !m_lock && !flush_i);
    chk({tag, "_out_valid"}, out_valid_o, (mq.size() != 0) && !flush_i);
    chk({tag, "_count"},     count_o, mq.size());
    chk({tag, "_ex_pend"},   ex_pending_o, m_lock);
    if (mq.size() != 0 && !flush_i) begin
      chk({tag, "_pc"},    out_pc_o,       mq[0].pc);
      chk({tag, "_inst"},  out_inst_o,     mq[0].inst);
      chk({tag, "_ex"},    out_ex_valid_o, mq[0].ex);
      chk({tag, "_cause"}, out_ex_cause_o, mq[0].cause);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, flush, valid;
    logic [ADDR_W-1:0] pc;
    logic ex;
    logic [CAUSE_W-1:0] cause;
    logic ordy;
    logic [CNT_W-1:0] e_cnt;
    logic e_ov, e_ir, e_ep;
    logic [ADDR_W-1:0] e_pc;
    logic e_hex;
    logic [CAUSE_W-1:0] e_hcause;
    logic e_zero;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, flush, valid, input logic [ADDR_W-1:0] pc,
                              input logic ex, input logic [CAUSE_W-1:0] cause, input logic ordy,
                              input logic [CNT_W-1:0] cnt, input logic ov, ir, ep,
                              input logic [ADDR_W-1:0] hpc, input logic hex,
                              input logic [CAUSE_W-1:0] hcause, input logic zero);
    vec_t v;
    v = '{rst: rst, flush: flush, valid: valid, pc: pc, ex: ex, cause: cause, ordy: ordy,
          e_cnt: cnt, e_ov: ov, e_ir: ir, e_ep: ep, e_pc: hpc, e_hex: hex,
          e_hcause: hcause, e_zero: zero};
    return v;
  endfunction

  initial begin
    // Expectations are the outputs seen during the cycle the inputs are applied.
    //                rst flush vld pc        ex cause ordy  cnt ov ir ep head_pc  hex hcause zero
    // back-to-back pushes, then drain in order
    vecs.push_back(mk(0, 0, 1, 40'h1000, 0, 0, 0,   0, 0, 1, 0, 40'h0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 40'h1004, 0, 0, 0,   1, 1, 1, 0, 40'h1000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 40'h1008, 0, 0, 0,   2, 1, 1, 0, 40'h1000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 40'h0,    0, 0, 0,   3, 1, 1, 0, 40'h1000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 40'h0,    0, 0, 1,   3, 1, 1, 0, 40'h1000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 40'h0,    0, 0, 1,   2, 1, 1, 0, 40'h1004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 40'h0,    0, 0, 1,   1, 1, 1, 0, 40'h1008, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 40'h0,    0, 0, 0,   0, 0, 1, 0, 40'h0,    0, 0, 0));
    // fill to DEPTH, full + pop refuses the push
    vecs.push_back(mk(0, 0, 1, 40'h5000, 0, 0, 0,   0, 0, 1, 0, 40'h0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 40'h5004, 0, 0, 0,   1, 1, 1, 0, 40'h5000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 40'h5008, 0, 0, 0,   2, 1, 1, 0, 40'h5000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 40'h500c, 0, 0, 0,   3, 1, 1, 0, 40'h5000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 40'h5010, 0, 0, 1,   4, 1, 0, 0, 40'h5000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 40'h5010, 0, 0, 0,   3, 1, 1, 0, 40'h5004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 40'h0,    0, 0, 0,   4, 1, 0, 0, 40'h5004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 40'h0,    0, 0, 1,   4, 1, 0, 0, 40'h5004, 0, 0, 0));
    // flush with 3 entries and a push attempt
    vecs.push_back(mk(0, 1, 1, 40'h7777, 0, 0, 1,   3, 0, 0, 0, 40'h0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 40'h3000, 0, 0, 0,   0, 0, 1, 0, 40'h0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 40'h0,    0, 0, 0,   1, 1, 1, 0, 40'h3000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 40'h0,    0, 0, 1,   1, 1, 1, 0, 40'h3000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 40'h0,    0, 0, 0,   0, 0, 1, 0, 40'h0,    0, 0, 0));
    // exception lock
    vecs.push_back(mk(0, 0, 1, 40'h2000, 0, 0, 0,   0, 0, 1, 0, 40'h0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 40'h2004, 1, 1, 0,   1, 1, 1, 0, 40'h2000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 40'h2008, 0, 0, 0,   2, 1, 0, 1, 40'h2000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 40'h2008, 0, 0, 1,   2, 1, 0, 1, 40'h2000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 40'h2008, 0, 0, 1,   1, 1, 0, 1, 40'h2004, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 40'h2008, 0, 0, 0,   0, 0, 0, 1, 40'h0,    0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 40'h2008, 0, 0, 0,   0, 0, 0, 1, 40'h0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 40'h0,    0, 0, 0,   0, 0, 1, 0, 40'h0,    0, 0, 0));
    // reset mid-operation with a push in flight
    vecs.push_back(mk(0, 0, 1, 40'h6000, 0, 0, 0,   0, 0, 1, 0, 40'h0,    0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 40'h6004, 0, 0, 0,   1, 1, 1, 0, 40'h6000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 40'h6008, 0, 0, 0,   2, 1, 1, 0, 40'h6000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 40'h0,    0, 0, 0,   0, 0, 1, 0, 40'h0,    0, 0, 1));
  end

  // ---------------- main sequence ----------------
  initial begin
    drive(1, 0, 0, '0, '0, 0, '0, 0);
    step();
    step();

    // reset values
    drive(0, 0, 0, '0, '0, 0, '0, 0);
    chk("rst_in_ready",  in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_pc",        out_pc_o, 0);
    chk("rst_inst",      out_inst_o, 0);
    chk("rst_ex",        out_ex_valid_o, 0);
    chk("rst_cause",     out_ex_cause_o, 0);
    chk("rst_count",     count_o, 0);
    chk("rst_ex_pend",   ex_pending_o, 0);

    // directed table
    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.flush, v.valid, v.pc, inst_of(v.pc), v.ex, v.cause, v.ordy);
      chk($sformatf("vec%0d_count", i),     count_o, v.e_cnt);
      chk($sformatf("vec%0d_out_valid", i), out_valid_o, v.e_ov);
      chk($sformatf("vec%0d_in_ready", i),  in_ready_o, v.e_ir);
      chk($sformatf("vec%0d_ex_pend", i),   ex_pending_o, v.e_ep);
      if (v.e_ov) begin
        chk($sformatf("vec%0d_pc", i),    out_pc_o, v.e_pc);
        chk($sformatf("vec%0d_inst", i),  out_inst_o, inst_of(v.e_pc));
        chk($sformatf("vec%0d_ex", i),    out_ex_valid_o, v.e_hex);
        chk($sformatf("vec%0d_cause", i), out_ex_cause_o, v.e_hcause);
      end
      if (v.e_zero) begin
        chk($sformatf("vec%0d_zero_pc", i),    out_pc_o, 0);
        chk($sformatf("vec%0d_zero_inst", i),  out_inst_o, 0);
        chk($sformatf("vec%0d_zero_ex", i),    out_ex_valid_o, 0);
        chk($sformatf("vec%0d_zero_cause", i), out_ex_cause_o, 0);
      end
      step();
    end

    // steady stream across pointer wrap: one push and one pop per cycle
    for (int i = 0; i < 12; i++) begin
      logic [ADDR_W-1:0] pc;
      pc = 40'h4000 + ADDR_W'(4 * i);
      drive(0, 0, 1, pc, inst_of(pc), 0, '0, 1);
      cmp_model($sformatf("stream%0d", i));
      if (i > 0) begin
        chk($sformatf("stream%0d_cnt1", i), count_o, 1);
        chk($sformatf("stream%0d_head", i), out_pc_o, pc - ADDR_W'(4));
      end
      step();
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0]  pc;
      logic [CAUSE_W-1:0] cause;
      pc    = {$urandom, $urandom};
      cause = {$urandom, $urandom};
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
            $urandom_range(0, 99) < 70, pc, $urandom, $urandom_range(0, 99) < 6,
            cause, $urandom_range(0, 99) < 55);
      cmp_model($sformatf("rand%0d", i));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
